matrix_column_scanner: RTL and testbench

Sequential successor to the panel's combinational column decoder. Autonomously scans NUM_COLS columns of the LED matrix, driving exactly one active-low column line at a time for a programmable dwell time. Inserts programmable blanking between columns to suppress ghosting, and flags frame start so the row-data source can align its output. Sits between the panel controller (enable) and the column driver transistors.

---
 rtl/matrix_column_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_matrix_column_scanner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner: autonomous LED matrix column scanner.
// Drives one active-low column at a time for DWELL_CYCLES, with BLANK_CYCLES of
// all-off blanking before each column, and pulses frame_start on the first
// driven cycle of the first column of a frame.
// Optional build macro COL_SKIP_EN adds a skip_mask input; masked columns are
// never driven and take no time.
//
// state | meaning
// IDLE  | scan stopped, all columns off, col_idx 0
// BLANK | all columns off ahead of column col_idx
// DRIVE | column col_idx driven low
module matrix_column_scanner #(
  parameter int NUM_COLS     = 7,
  parameter int COL_W        = 3,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
`ifdef COL_SKIP_EN
  input  logic [NUM_COLS-1:0] skip_mask,
`endif
  output logic [NUM_COLS-1:0] col_n,
  output logic [COL_W-1:0]    col_idx,
  output logic                blank,
  output logic                frame_start
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [COL_W-1:0] LAST_IDX = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W:0]   NUM_IDX  = (COL_W + 1)'(NUM_COLS);

  state_t                r_state;
  logic [COL_W-1:0]      r_col_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_is_first;
  logic                  r_none;
  logic [NUM_COLS-1:0]   r_col_n;
  logic                  r_blank;
  logic                  r_frame_start;

  state_t                w_state_nxt;
  logic [COL_W-1:0]      w_idx_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_first_nxt;
  logic                  w_none_nxt;
  logic                  w_fs_nxt;
  logic [NUM_COLS-1:0]   w_col_n_nxt;
  logic [NUM_COLS-1:0]   w_mask;
  logic [COL_W-1:0]      w_adv_start;
  logic [COL_W:0]        w_low;
  logic [COL_W:0]        w_adv;
  logic                  w_idx_bad;

`ifdef COL_SKIP_EN
  assign w_mask = skip_mask;
`else
  assign w_mask = '0;
`endif

  // Returns {found, index} of the first unmasked column at or after start, with wrap.
  function automatic logic [COL_W:0] f_search(input logic [NUM_COLS-1:0] mask,
                                              input logic [COL_W-1:0] start);
    logic             found;
    logic [COL_W-1:0] res;
    int               j;
    found = 1'b0;
    res   = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      j = int'(start) + k;
      if (j >= NUM_COLS) j = j - NUM_COLS;
      if (!found && !mask[j]) begin
        found = 1'b1;
        res   = COL_W'(j);
      end
    end
    return {found, res};
  endfunction

  assign w_adv_start = (r_col_idx == LAST_IDX) ? '0 : r_col_idx + 1'b1;
  assign w_low       = f_search(w_mask, '0);
  assign w_adv       = f_search(w_mask, w_adv_start);
  assign w_idx_bad   = ({1'b0, r_col_idx} >= NUM_IDX);

  // Next-state, next-column and counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_col_idx;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_is_first;
    w_none_nxt  = r_none;
    w_fs_nxt    = 1'b0;
    if (!enable || w_idx_bad) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_first_nxt = 1'b0;
      w_none_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_low[COL_W]) begin
            // every column masked: park in blanking
            w_state_nxt = S_BLANK;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_first_nxt = 1'b0;
            w_none_nxt  = 1'b1;
          end else begin
            w_idx_nxt   = w_low[COL_W-1:0];
            w_first_nxt = 1'b1;
            w_none_nxt  = 1'b0;
            if (BLANK_CYCLES == 0) begin
              w_state_nxt = S_DRIVE;
              w_cnt_nxt   = DWELL_LD;
              w_fs_nxt    = 1'b1;
            end else begin
              w_state_nxt = S_BLANK;
              w_cnt_nxt   = BLANK_LD;
            end
          end
        end
        S_BLANK: begin
          if (!r_none) begin
            if (r_cnt == '0) begin
              w_state_nxt = S_DRIVE;
              w_cnt_nxt   = DWELL_LD;
              w_fs_nxt    = r_is_first;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (r_cnt == '0) begin
            if (!w_adv[COL_W]) begin
              w_state_nxt = S_BLANK;
              w_idx_nxt   = '0;
              w_cnt_nxt   = '0;
              w_first_nxt = 1'b0;
              w_none_nxt  = 1'b1;
            end else begin
              w_idx_nxt   = w_adv[COL_W-1:0];
              w_first_nxt = (w_adv[COL_W-1:0] == w_low[COL_W-1:0]);
              if (BLANK_CYCLES == 0) begin
                w_state_nxt = S_DRIVE;
                w_cnt_nxt   = DWELL_LD;
                w_fs_nxt    = (w_adv[COL_W-1:0] == w_low[COL_W-1:0]);
              end else begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = BLANK_LD;
              end
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_first_nxt = 1'b0;
          w_none_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Column drive decoded from the next state so at most one bit is ever low.
  always_comb begin
    w_col_n_nxt = '1;
    for (int i = 0; i < NUM_COLS; i++) begin
      w_col_n_nxt[i] = !((w_state_nxt == S_DRIVE) && (w_idx_nxt == COL_W'(i)));
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_col_idx     <= '0;
      r_cnt         <= '0;
      r_is_first    <= 1'b0;
      r_none        <= 1'b0;
      r_col_n       <= '1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_col_idx     <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_is_first    <= w_first_nxt;
      r_none        <= w_none_nxt;
      r_col_n       <= w_col_n_nxt;
      r_blank       <= (w_state_nxt != S_DRIVE);
      r_frame_start <= w_fs_nxt;
    end
  end

  assign col_n       = r_col_n;
  assign col_idx     = r_col_idx;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Testbench for matrix_column_scanner: two instances (blanked and zero-blank)
// checked cycle by cycle against a timing model through expected-value queues.
module tb_matrix_column_scanner;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [6:0] col_n_a, col_n_b;
  logic [2:0] col_idx_a, col_idx_b;
  logic       blank_a, blank_b;
  logic       fs_a, fs_b;
`ifdef COL_SKIP_EN
  logic [6:0] skip_mask;
`endif

  int         n_chk;
  int         n_err;
  bit         m_run;
  int         m_t;
  logic [6:0] m_mask;
  logic [11:0] q_a[$];
  logic [11:0] q_b[$];

  matrix_column_scanner #(
    .NUM_COLS(7), .COL_W(3), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(16)
  ) u_dut_a (
    .clk(clk),
    .reset(reset),
    .enable(enable),
`ifdef COL_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .col_n(col_n_a),
    .col_idx(col_idx_a),
    .blank(blank_a),
    .frame_start(fs_a)
  );

  matrix_column_scanner #(
    .NUM_COLS(7), .COL_W(3), .DWELL_CYCLES(3), .BLANK_CYCLES(0), .CNT_W(16)
  ) u_dut_b (
    .clk(clk),
    .reset(reset),
    .enable(enable),
`ifdef COL_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .col_n(col_n_b),
    .col_idx(col_idx_b),
    .blank(blank_b),
    .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {col_n, col_idx, blank, frame_start} at output cycle t of a scan.
  function automatic logic [11:0] f_exp(input bit run, input int t, input int b, input int d,
                                        input logic [6:0] mask);
    int         order[7];
    int         n, p, k, ph, col;
    logic [6:0] cn;
    logic [2:0] ci;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      order[i] = 0;
    end
    for (int i = 0; i < 7; i++) begin
      if (!mask[i]) begin
        order[n] = i;
        n++;
      end
    end
    if (!run || n == 0) return {7'h7f, 3'd0, 1'b1, 1'b0};
    p   = b + d;
    k   = (t / p) % n;
    ph  = t % p;
    col = order[k];
    ci  = 3'(col);
    if (ph < b) return {7'h7f, ci, 1'b1, 1'b0};
    cn = 7'h7f;
    cn[col] = 1'b0;
    return {cn, ci, 1'b0, (k == 0 && ph == b)};
  endfunction

  task automatic step(input logic en, input logic rs);
    logic [11:0] e;
    @(negedge clk);
    enable = en;
    reset  = rs;
    if (rs) m_run = 1'b0;
    else if (en) begin
      if (m_run) m_t++;
      else begin
        m_run = 1'b1;
        m_t   = 0;
      end
    end else m_run = 1'b0;
    q_a.push_back(f_exp(m_run, m_t, 2, 4, m_mask));
    q_b.push_back(f_exp(m_run, m_t, 0, 3, m_mask));
    @(posedge clk);
    #1;
    if (q_a.size() == 0) chk("queue_a", 0, 1);
    else begin
      e = q_a.pop_front();
      chk("scan_a", {col_n_a, col_idx_a, blank_a, fs_a}, e);
    end
    if (q_b.size() == 0) chk("queue_b", 0, 1);
    else begin
      e = q_b.pop_front();
      chk("scan_b", {col_n_b, col_idx_b, blank_b, fs_b}, e);
    end
    chk("onehot_a", ($countones(~col_n_a) <= 1), 1);
    chk("onehot_b", ($countones(~col_n_b) <= 1), 1);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    m_run  = 1'b0;
    m_t    = 0;
    m_mask = '0;
    reset  = 1'b1;
    enable = 1'b0;
`ifdef COL_SKIP_EN
    skip_mask = '0;
`endif

    // reset and idle
    step(0, 1);
    step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    // nominal scan over more than two frames
    for (int i = 0; i < 100; i++) step(1, 0);

    // drop enable in the second cycle of column 3, then restart
    step(0, 0);
    for (int i = 0; i < 22; i++) step(1, 0);
    step(0, 0);
    for (int i = 0; i < 10; i++) step(1, 0);

    // async reset while column 0 is driven
    step(0, 0);
    for (int i = 0; i < 4; i++) step(1, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_col_n_a", col_n_a, 7'h7f);
    chk("async_blank_a", blank_a, 1'b1);
    chk("async_col_n_b", col_n_b, 7'h7f);
    chk("async_blank_b", blank_b, 1'b1);
    step(1, 1);
    for (int i = 0; i < 12; i++) step(1, 0);

`ifdef COL_SKIP_EN
    skip_mask = 7'b0100101;
    m_mask    = 7'b0100101;
    step(0, 0);
    for (int i = 0; i < 60; i++) step(1, 0);
    skip_mask = 7'b1111111;
    m_mask    = 7'b1111111;
    step(0, 0);
    for (int i = 0; i < 15; i++) step(1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
